score_to_digits: RTL and testbench



---
 rtl/display_pkg.sv | 28 ++
 rtl/bcd_add3.sv | 15 +
 rtl/score_to_digits.sv | 108 ++++++++++
 tb/tb_score_to_digits.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// ---- display_pkg: shared types and constants for the seven-segment display path. rev 1.0 ----
`default_nettype none

package display_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Every digit blanked except digit 0; callers slice to their digit count.
  function automatic logic [63:0] blank_reset(input int digits);
    return ((64'd1 << digits) - 64'd1) & ~64'd1;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_add3.sv
// ---- bcd_add3: single-digit double-dabble corrector (add 3 when digit >= 5). rev 1.0 ----
`default_nettype none

module bcd_add3
  import display_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] digit_out
);

  assign digit_out = (digit_in >= DIGIT_W'(5)) ? digit_in + DIGIT_W'(3) : digit_in;

endmodule

`default_nettype wire

// File: rtl/score_to_digits.sv
// ---- score_to_digits: iterative binary-to-BCD converter with leading-zero blank mask. rev 1.0 ----
`default_nettype none

module score_to_digits
  import display_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
)
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [BIN_W-1:0]            bin_in,
  output logic                        busy,
  output logic                        done,
  output logic [DIGIT_W*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]           blank
);

  localparam int SCR_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [DIGITS-1:0] BLANK_INIT = DIGITS'(blank_reset(DIGITS));

  if (((64'd1 << BIN_W) - 64'd1) > (pow10(DIGITS) - 64'd1)) begin : g_range_check
    $error("score_to_digits: DIGITS too small to hold 2^BIN_W-1");
  end

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   shreg;
  logic [SCR_W-1:0]   scratch;
  logic [SCR_W-1:0]   corrected;
  logic [SCR_W+BIN_W-1:0] shifted;
  logic [DIGITS-1:0]  blank_next;
  logic               zero_above;
  logic               load, shift_en, finish;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_add3 u_add3 (
      .digit_in  (scratch[DIGIT_W*k +: DIGIT_W]),
      .digit_out (corrected[DIGIT_W*k +: DIGIT_W])
    );
  end

  // The corrected scratch's top bit falls off here; the range check guarantees it is zero.
  assign shifted = {corrected, shreg} << 1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load     = (state == IDLE) && start;
    shift_en = (state == SHIFT);
    finish   = (state == DONE);
  end

  always_comb begin
    zero_above = 1'b1;
    blank_next = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above    = zero_above & (scratch[DIGIT_W*k +: DIGIT_W] == '0);
      blank_next[k] = zero_above;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      blank   <= BLANK_INIT;
    end else begin
      busy <= (next_state != IDLE);
      done <= finish;
      if (load) begin
        shreg   <= bin_in;
        scratch <= '0;
        cnt     <= CNT_W'(BIN_W);
      end else if (shift_en) begin
        {scratch, shreg} <= shifted;
        cnt              <= cnt - CNT_W'(1);
      end
      if (finish) begin
        bcd_out <= scratch;
        blank   <= blank_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_score_to_digits.sv
// ---- tb_score_to_digits: randomized and sweep stimulus against a decimal reference model. rev 1.0 ----
`default_nettype none

module tb_score_to_digits;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic [3:0]  blank;

  int n_checks;
  int n_fail;

  score_to_digits #(.BIN_W(10), .DIGITS(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .blank   (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Digit k is blanked when the value has fewer than k+1 significant decimal digits.
  function automatic logic [3:0] model_blank(input int v);
    logic [3:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 1; k < 4; k++) begin
      p = p * 10;
      r[k] = (v < p);
    end
    return r;
  endfunction

  // Caller must be at a negedge; start is driven immediately.
  task automatic run_conv(input int v, input int poke_at, input int rst_at, output int lat);
    logic [15:0] prev_bcd;
    logic [3:0]  prev_blank;
    bit          aborted;
    prev_bcd   = bcd_out;
    prev_blank = blank;
    aborted    = 1'b0;
    start  = 1'b1;
    bin_in = 10'(v);
    @(negedge clk);
    start  = 1'b0;
    bin_in = 10'($urandom);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      chk("busy_during", {31'd0, busy}, 32'd1);
      chk("hold_bcd", {16'd0, bcd_out}, {16'd0, prev_bcd});
      chk("hold_blank", {28'd0, blank}, {28'd0, prev_blank});
      if (lat == poke_at) begin
        start  = 1'b1;
        bin_in = 10'd5;
      end else begin
        start  = 1'b0;
      end
      if (lat == rst_at) reset = 1'b1;
      @(negedge clk);
      lat++;
      if (reset) begin
        reset   = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (aborted) begin
      lat = -1;
    end else begin
      chk("latency", 32'(lat), 32'd11);
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      chk("bcd_value", {16'd0, bcd_out}, {16'd0, model_bcd(v)});
      chk("blank_value", {28'd0, blank}, {28'd0, model_blank(v)});
      for (int k = 0; k < 4; k++)
        chk("digit_range", {31'd0, (bcd_out[4*k +: 4] <= 4'd9)}, 32'd1);
    end
  endtask

  int lat;
  int v;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_bcd", {16'd0, bcd_out}, 32'h0);
    chk("rst_blank", {28'd0, blank}, 32'b1110);
    reset = 1'b0;
    @(negedge clk);

    run_conv(0, -1, -1, lat);
    @(negedge clk);
    run_conv(1023, -1, -1, lat);
    @(negedge clk);

    // Back-to-back: second start driven during the done cycle.
    run_conv(999, -1, -1, lat);
    run_conv(7, -1, -1, lat);
    @(negedge clk);

    // Start pulsed mid-conversion must be ignored and not queued.
    run_conv(512, 3, -1, lat);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("no_extra_done", {31'd0, done}, 32'd0);
      chk("hold_after_ignore", {16'd0, bcd_out}, 32'h0512);
    end

    // Reset mid-conversion discards it.
    run_conv(345, -1, 5, lat);
    chk("rst_aborted", 32'(lat), 32'hFFFF_FFFF);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_bcd", {16'd0, bcd_out}, 32'h0);
    chk("rst_mid_blank", {28'd0, blank}, 32'b1110);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", {31'd0, done}, 32'd0);
    end
    run_conv(345, -1, -1, lat);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(0, 1023));
      run_conv(v, -1, -1, lat);
      if (($urandom & 1) == 1) repeat (int'($urandom_range(1, 3))) @(negedge clk);
    end

    for (int i = 0; i < 1024; i++) run_conv(i, -1, -1, lat);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
